// File: rtl/fft_twiddle_sequencer.sv
// Generic FIFO: registered storage, head presented combinationally from memory.
// Latency: a word written on edge N is visible at rd_dat after edge N.
// Backpressure: holds the head while rd_rdy is low; a push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] cnt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  assign rd_vld = (cnt_q != '0);
  assign pop    = rd_vld && rd_rdy;
  assign push   = wr_vld && ((cnt_q != CW'(DEPTH)) || pop);
  assign rd_dat = mem[rd_ptr];
  assign cnt    = cnt_q;

  // Storage, pointers and occupancy; the memory is cleared so an empty FIFO presents zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// FFT twiddle sequencer: walks stage/butterfly, reads the twiddle ROMs, streams pairs out.
// Latency: first tw_valid two edges after the start edge, then one pair per cycle.
// Backpressure: at most two reads outstanding (FIFO + in flight); tw_ready low freezes issue and output.
module fft_twiddle_sequencer #(
  parameter int LOG2N  = 6,
  parameter int DATA_W = 16,
  parameter int ADDR_W = LOG2N - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [2:0]        tw_stage,
  output logic              tw_last
);

  localparam int          BW   = LOG2N - 1;
  localparam logic [BW-1:0] BMAX = '1;
  localparam logic [2:0]  SMAX = 3'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [2:0]        stage;
    logic              last;
  } tw_t;

  localparam int TW_W = $bits(tw_t);

  state_t            state_q, state_d;
  logic [2:0]        s_q;
  logic [BW-1:0]     b_q;
  logic [ADDR_W-1:0] addr_q, issue_addr;
  logic [2:0]        shamt;
  logic [BW-1:0]     bmask, shifted;
  logic [2:0]        occ;
  logic              issue, last_issue, pop;
  logic              inf_vld, inf_last;
  logic [2:0]        inf_stage;
  logic [1:0]        fifo_cnt;
  tw_t               wr_word, head;

  assign pop = tw_valid && tw_ready;

  // Twiddle address: keep the low s bits of b and scale them up to the ROM's full index range.
  always_comb begin
    shamt      = SMAX - s_q;
    bmask      = BMAX >> shamt;
    shifted    = (b_q & bmask) << shamt;
    issue_addr = ADDR_W'(shifted);
  end

  // The ROM registers rom_addr itself, so the issued address is driven straight through
  // on the issue cycle and the held copy is shown otherwise.
  assign rom_addr = issue ? issue_addr : addr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, issue decision and status outputs; a pop this cycle frees a slot for the next read.
  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    occ        = {1'b0, fifo_cnt} + {2'b00, inf_vld};
    issue      = (state_q == RUN) && (occ < (3'd2 + {2'b00, pop}));
    last_issue = issue && (s_q == SMAX) && (b_q == BMAX);
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (!inf_vld && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage/butterfly counters and held address; counters wrap to zero after the final read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      b_q    <= '0;
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= issue_addr;
      if (b_q == BMAX) begin
        b_q <= '0;
        s_q <= (s_q == SMAX) ? 3'd0 : s_q + 3'd1;
      end else begin
        b_q <= b_q + 1'b1;
      end
    end
  end

  // In-flight tag for the read whose data the ROM presents next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inf_vld   <= 1'b0;
      inf_stage <= '0;
      inf_last  <= 1'b0;
    end else begin
      inf_vld   <= issue;
      inf_stage <= s_q;
      inf_last  <= last_issue;
    end
  end

  assign wr_word.re    = rom_re_data;
  assign wr_word.im    = rom_im_data;
  assign wr_word.stage = inf_stage;
  assign wr_word.last  = inf_last;

  sync_fifo #(.W(TW_W), .DEPTH(2)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (inf_vld),
    .wr_dat (wr_word),
    .rd_vld (tw_valid),
    .rd_rdy (tw_ready),
    .rd_dat (head),
    .cnt    (fifo_cnt)
  );

  assign tw_re    = head.re;
  assign tw_im    = head.im;
  assign tw_stage = head.stage;
  assign tw_last  = head.last;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
module tb_fft_twiddle_sequencer;

  localparam int LOG2N  = 6;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NBF    = 32;
  localparam int NPAIR  = 192;

  logic              clk = 1'b0;
  logic              rst, start, tw_ready;
  logic              busy, done, tw_valid, tw_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_re_data = '0;
  logic [DATA_W-1:0] rom_im_data = '0;
  logic [DATA_W-1:0] tw_re, tw_im;
  logic [2:0]        tw_stage;

  int vectors     = 0;
  int miscompares = 0;
  logic [35:0] exp_q [$];

  fft_twiddle_sequencer #(.LOG2N(LOG2N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_re_data (rom_re_data),
    .rom_im_data (rom_im_data),
    .tw_valid    (tw_valid),
    .tw_ready    (tw_ready),
    .tw_re       (tw_re),
    .tw_im       (tw_im),
    .tw_stage    (tw_stage),
    .tw_last     (tw_last)
  );

  always #5 clk = ~clk;

  // Twiddle ROMs with one registered cycle of latency; contents derived from the address.
  always @(posedge clk) begin
    rom_re_data <= DATA_W'(rom_addr);
    rom_im_data <= ~DATA_W'(rom_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] exp_pair(input int s, input int b);
    int          a;
    logic [15:0] a16;
    a   = (b % (1 << s)) * (1 << (LOG2N - 1 - s));
    a16 = 16'(a);
    return {a16, ~a16, 3'(s), (s == LOG2N - 1) && (b == NBF - 1)};
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},     64'(busy),     64'(0));
    chk({tag, "_done"},     64'(done),     64'(0));
    chk({tag, "_valid"},    64'(tw_valid), 64'(0));
    chk({tag, "_re"},       64'(tw_re),    64'(0));
    chk({tag, "_im"},       64'(tw_im),    64'(0));
    chk({tag, "_stage"},    64'(tw_stage), 64'(0));
    chk({tag, "_last"},     64'(tw_last),  64'(0));
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
  endtask

  // mode 0: ready high; 1: ready 30% random; 2: ready low for the first 20 cycles.
  // rst_at > 0 aborts the run with reset after that many handshakes; pulse re-pulses start mid-run.
  task automatic run_fft(input int mode, input int rst_at, input bit pulse);
    int          hs, dn, first_v, first_dec, last_dec, done_step;
    logic [35:0] held, got;
    logic        stalled;
    logic [ADDR_W-1:0] addr_snap;
    exp_q.delete();
    for (int s = 0; s < LOG2N; s++)
      for (int b = 0; b < NBF; b++)
        exp_q.push_back(exp_pair(s, b));
    hs = 0; dn = 0; first_v = -1; first_dec = -1; last_dec = -1; done_step = -1;
    stalled = 1'b0; held = '0; addr_snap = '0;
    start = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      got = {tw_re, tw_im, tw_stage, tw_last};
      if (tw_valid && first_v < 0) first_v = k;
      if (stalled) chk("stall_hold", 64'(got), 64'(held));
      if (done) begin
        dn++;
        done_step = k;
        chk("done_gap", 64'(k - last_dec), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(1));
      end
      if (mode == 2 && k == 3) addr_snap = rom_addr;
      if (mode == 2 && k == 20) begin
        chk("stall_rom_addr", 64'(rom_addr), 64'(addr_snap));
        chk("stall_valid", 64'(tw_valid), 64'(1));
      end
      if (rst_at > 0 && hs == rst_at) begin
        rst = 1'b1;
        #1;
        reset_checks("mid_rst");
        break;
      end
      if (done_step > 0 && k == done_step + 2) begin
        chk("idle_busy", 64'(busy), 64'(0));
        break;
      end
      case (mode)
        0:       tw_ready = 1'b1;
        1:       tw_ready = ($urandom_range(0, 99) < 30);
        default: tw_ready = (k > 20);
      endcase
      stalled = tw_valid && !tw_ready;
      held    = got;
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) chk("pair_count", 64'(hs + 1), 64'(NPAIR));
        else                   chk("pair", 64'(got), 64'(exp_q.pop_front()));
        hs++;
        if (first_dec < 0) first_dec = k;
        last_dec = k;
        if (pulse && (hs == 100 || hs == NPAIR)) start = 1'b1;
      end
    end
    chk("first_valid_step", 64'(first_v), 64'(3));
    if (rst_at > 0) begin
      chk("rst_reached", 64'(hs), 64'(rst_at));
      chk("no_done_on_abort", 64'(dn), 64'(0));
    end else begin
      chk("handshakes", 64'(hs), 64'(NPAIR));
      chk("done_count", 64'(dn), 64'(1));
      chk("exp_left", 64'(exp_q.size()), 64'(0));
      if (mode == 0) chk("throughput", 64'(last_dec - first_dec + 1), 64'(NPAIR));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b0;
    @(posedge clk); #1;
    run_fft(0, 0, 1'b0);
    run_fft(1, 0, 1'b0);
    run_fft(1, 0, 1'b1);
    run_fft(2, 0, 1'b0);
    run_fft(0, 70, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_fft(0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
